// File: rtl/rc5_fifo.sv
// rtl/rc5_fifo.sv - RC5 frame filter, repeat suppressor and CSR-read FIFO with level irq
// Optional macro RC5_EXT_EN: accept S2=0 frames and expose ~S2 as DATA[6].
module rc5_fifo #(
    parameter logic [4:0] csr_addr   = 5'h0,
    parameter int         clk_freq   = 100000000,
    parameter int         depth_log2 = 3,
    parameter int         repeat_ms  = 120
) (
    input  logic        sys_clk,
    input  logic        sys_rst_n,
    input  logic [12:0] frame_data,
    input  logic        frame_stb,
    input  logic [14:0] csr_a,
    input  logic        csr_we,
    input  logic [31:0] csr_di,
    output logic [31:0] csr_do,
    output logic        irq
);
    localparam int                  depth    = 1 << depth_log2;
    localparam logic [23:0]         win_m1   = 24'(clk_freq / 1000 * repeat_ms - 1);
    localparam logic [depth_log2:0] full_lvl = (depth_log2 + 1)'(depth);
    localparam logic [depth_log2:0] lvl_one  = (depth_log2 + 1)'(1);
    localparam logic [depth_log2-1:0] ptr_one = depth_log2'(1);

    logic [2:0]  ctrl;
    logic [4:0]  filt_addr;
    logic        filt_en;
    logic        overflow;
    logic [11:0] last_tuple;
    logic [23:0] timer;
    logic        s1_vld;
    logic [12:0] s1_entry;
    logic [12:0] mem [depth];
    logic [depth_log2-1:0] wr_ptr, rd_ptr;
    logic [depth_log2:0]   level;

    logic        f_s2, f_t, s2_ok, ext_bit;
    logic [4:0]  f_addr;
    logic [5:0]  f_cmd;
    logic [11:0] tuple;
    logic        pre_ok, match, accept, reload;

    assign f_s2   = frame_data[12];
    assign f_t    = frame_data[11];
    assign f_addr = frame_data[10:6];
    assign f_cmd  = frame_data[5:0];
    assign tuple  = {f_t, f_addr, f_cmd};

`ifdef RC5_EXT_EN
    assign s2_ok   = 1'b1;
    assign ext_bit = ~f_s2;
`else
    assign s2_ok   = f_s2;
    assign ext_bit = 1'b0;
`endif

    assign pre_ok = ctrl[0] && s2_ok && (!filt_en || f_addr == filt_addr);
    assign match  = (tuple == last_tuple);
    assign accept = pre_ok && !(ctrl[1] && timer != 24'd0 && match);
    // a held key keeps the window open even while its frames are being dropped
    assign reload = frame_stb && pre_ok && (match || accept);

    logic       sel, pop_req, empty, full, do_pop, do_push;
    logic [12:0] head;
    logic [31:0] rdata;

    assign sel     = (csr_a[14:10] == csr_addr);
    assign pop_req = sel && csr_we && csr_a[1:0] == 2'd0;
    assign empty   = (level == '0);
    assign full    = (level == full_lvl);
    assign do_pop  = pop_req && !empty;
    assign do_push = s1_vld && (!full || do_pop);
    assign head    = empty ? 13'd0 : mem[rd_ptr];

    always_comb begin
        rdata = '0;
        case (csr_a[1:0])
            2'd0: begin
                rdata[31]   = ~empty;
                rdata[12:0] = head;
            end
            2'd1: begin
                rdata[depth_log2:0] = level;
                rdata[16] = empty;
                rdata[17] = full;
                rdata[18] = overflow;
            end
            2'd2:    rdata[2:0] = ctrl;
            default: begin
                rdata[4:0] = filt_addr;
                rdata[8]   = filt_en;
            end
        endcase
    end

    always_ff @(posedge sys_clk) begin
        if (do_push) mem[wr_ptr] <= s1_entry;
    end

    always_ff @(posedge sys_clk or negedge sys_rst_n) begin
        if (!sys_rst_n) begin
            ctrl       <= '0;
            filt_addr  <= '0;
            filt_en    <= 1'b0;
            overflow   <= 1'b0;
            last_tuple <= '0;
            timer      <= '0;
            s1_vld     <= 1'b0;
            s1_entry   <= '0;
            wr_ptr     <= '0;
            rd_ptr     <= '0;
            level      <= '0;
            csr_do     <= '0;
            irq        <= 1'b0;
        end else begin
            csr_do <= sel ? rdata : 32'd0;
            irq    <= ctrl[2] && !empty;

            if (sel && csr_we) begin
                case (csr_a[1:0])
                    2'd1: if (csr_di[18]) overflow <= 1'b0;
                    2'd2: ctrl <= csr_di[2:0];
                    2'd3: begin
                        filt_addr <= csr_di[4:0];
                        filt_en   <= csr_di[8];
                    end
                    default: ;
                endcase
            end
            if (s1_vld && !do_push) overflow <= 1'b1;

            s1_vld   <= frame_stb && accept;
            s1_entry <= {f_t, f_addr, ext_bit, f_cmd};
            if (frame_stb && accept) last_tuple <= tuple;
            if (reload)                timer <= win_m1;
            else if (timer != 24'd0)   timer <= timer - 24'd1;

            if (do_push) wr_ptr <= wr_ptr + ptr_one;
            if (do_pop)  rd_ptr <= rd_ptr + ptr_one;
            case ({do_push, do_pop})
                2'b10:   level <= level + lvl_one;
                2'b01:   level <= level - lvl_one;
                default: ;
            endcase
        end
    end

    logic unused_bits;
    assign unused_bits = ^{csr_di[31:19], csr_di[17:9], csr_di[7:5], csr_a[9:2]};
endmodule

// File: tb/tb_rc5_fifo.sv
// tb/tb_rc5_fifo.sv - self-checking bench for rc5_fifo with a queue-based reference model
module tb_rc5_fifo;
    localparam logic [4:0] SEL = 5'h3;
    localparam int CF  = 50000;
    localparam int DL  = 3;
    localparam int RMS = 120;
    localparam int W   = CF / 1000 * RMS;
    localparam int MS  = CF / 1000;
    localparam int D   = 1 << DL;

    logic        clk = 1'b0;
    logic        rst_n = 1'b0;
    logic [12:0] frame_data = '0;
    logic        frame_stb = 1'b0;
    logic [14:0] csr_a = '0;
    logic        csr_we = 1'b0;
    logic [31:0] csr_di = '0;
    logic [31:0] csr_do;
    logic        irq;

    int total = 0;
    int bad   = 0;
    int shown = 0;

    always #5 clk = ~clk;

    rc5_fifo #(.csr_addr(SEL), .clk_freq(CF), .depth_log2(DL), .repeat_ms(RMS)) dut (
        .sys_clk(clk), .sys_rst_n(rst_n), .frame_data(frame_data), .frame_stb(frame_stb),
        .csr_a(csr_a), .csr_we(csr_we), .csr_di(csr_di), .csr_do(csr_do), .irq(irq)
    );

    // reference model: FIFO as a queue, repeat window as "cycles since last reload"
    int          q[$];
    bit          m_ovf;
    bit [2:0]    m_ctrl;
    bit [4:0]    m_fa;
    bit          m_fe;
    bit [11:0]   m_last;
    longint      m_rel = -1000000;
    longint      m_cyc = 0;
    bit          m_pend;
    bit [12:0]   m_pe;
    logic [31:0] exp_do = '0;
    logic        exp_irq = 1'b0;

    function automatic logic [31:0] m_read(input logic [1:0] r);
        case (r)
            2'd0: return (q.size() > 0) ? (32'h8000_0000 | 32'(q[0])) : 32'd0;
            2'd1: return 32'(q.size()) | ((q.size() == 0) ? 32'h1_0000 : 32'd0)
                       | ((q.size() == D) ? 32'h2_0000 : 32'd0) | (m_ovf ? 32'h4_0000 : 32'd0);
            2'd2: return {29'd0, m_ctrl};
            default: return {23'd0, m_fe, 3'd0, m_fa};
        endcase
    endfunction

    task automatic m_step();
        bit sel, pop, dpop, can_push, ok, running, match, drop_rep, ext;
        bit [1:0] r;
        bit [11:0] tup;
        int tmp;
        sel = (csr_a[14:10] == SEL);
        r   = csr_a[1:0];
        exp_do  = sel ? m_read(r) : 32'd0;
        exp_irq = m_ctrl[2] && q.size() > 0;
        pop      = sel && csr_we && r == 2'd0;
        dpop     = pop && q.size() > 0;
        can_push = (q.size() < D) || dpop;
        if (sel && csr_we && r == 2'd1 && csr_di[18]) m_ovf = 1'b0;
        if (dpop) tmp = q.pop_front();
        if (m_pend) begin
            if (can_push) q.push_back(int'(m_pe));
            else m_ovf = 1'b1;
        end
        m_pend = 1'b0;
        if (frame_stb) begin
`ifdef RC5_EXT_EN
            ext = 1'b1;
`else
            ext = 1'b0;
`endif
            ok = m_ctrl[0] && (ext || frame_data[12]) && (!m_fe || frame_data[10:6] == m_fa);
            tup = frame_data[11:0];
            running  = (m_cyc - m_rel) < W;
            match    = (tup == m_last);
            drop_rep = m_ctrl[1] && running && match;
            if (ok && (match || !drop_rep)) m_rel = m_cyc;
            if (ok && !drop_rep) begin
                m_last = tup;
                m_pend = 1'b1;
                m_pe   = {frame_data[11:6], ext & ~frame_data[12], frame_data[5:0]};
            end
        end
        if (sel && csr_we && r == 2'd2) m_ctrl = csr_di[2:0];
        if (sel && csr_we && r == 2'd3) begin
            m_fa = csr_di[4:0];
            m_fe = csr_di[8];
        end
        m_cyc++;
    endtask

    task automatic m_reset();
        q.delete();
        m_ovf = 0; m_ctrl = 0; m_fa = 0; m_fe = 0; m_last = 0;
        m_rel = m_cyc - 1000000; m_pend = 0; exp_do = 0; exp_irq = 0;
    endtask

    initial forever begin
        @(posedge clk or negedge rst_n);
        if (!rst_n) m_reset();
        else m_step();
    end

    initial forever begin
        @(negedge clk);
        total++;
        if (csr_do !== exp_do || irq !== exp_irq) begin
            bad++;
            if (shown < 10) $display("FAIL cycle_compare t=%0t csr_do=%h irq=%b expected csr_do=%h irq=%b",
                                     $time, csr_do, irq, exp_do, exp_irq);
            shown++;
        end
    end

    task automatic chk(input string name, input logic [31:0] got, input logic [31:0] exp);
        total++;
        if (got !== exp) begin
            bad++;
            $display("FAIL %s got=%h expected=%h", name, got, exp);
        end
    endtask

    task automatic rd(input logic [1:0] r, output logic [31:0] d);
        @(negedge clk);
        csr_a = {SEL, 8'h00, r};
        csr_we = 1'b0;
        @(posedge clk);
        #1 d = csr_do;
    endtask

    task automatic wr(input logic [1:0] r, input logic [31:0] v);
        @(negedge clk);
        csr_a = {SEL, 8'h00, r};
        csr_di = v;
        csr_we = 1'b1;
        @(negedge clk);
        csr_we = 1'b0;
        csr_a = '0;
    endtask

    task automatic stb(input logic [12:0] f, input int gap_ms);
        @(negedge clk);
        frame_data = f;
        frame_stb = 1'b1;
        @(negedge clk);
        frame_stb = 1'b0;
        repeat (gap_ms * MS) @(negedge clk);
    endtask

    task automatic status_is(input string name, input logic [31:0] exp);
        logic [31:0] d;
        rd(2'd1, d);
        chk(name, d, exp);
    endtask

    logic [31:0] d;

    initial begin
        repeat (3) @(negedge clk);
        chk("reset_csr_do", csr_do, 32'd0);
        chk("reset_irq", {31'd0, irq}, 32'd0);
        rst_n = 1'b1;
        status_is("reset_status", 32'h0001_0000);

        // basic accept, readout, irq and pop
        wr(2'd2, 32'h5);
        stb(13'h1A4C, 1);
        status_is("one_level", 32'h0000_0001);
        rd(2'd0, d);
        chk("one_data", d, 32'h8000_148C);
        chk("one_irq", {31'd0, irq}, 32'd1);
        @(negedge clk);
        csr_a = 15'h0001;
        @(posedge clk);
        #1 chk("unselected_bank", csr_do, 32'd0);
        wr(2'd0, 32'd0);
        status_is("pop_empty", 32'h0001_0000);
        chk("pop_irq", {31'd0, irq}, 32'd0);
        wr(2'd0, 32'd0);
        status_is("pop_on_empty", 32'h0001_0000);

        // S2=0 frame
        stb(13'h0A4F, 1);
`ifdef RC5_EXT_EN
        rd(2'd0, d);
        chk("s2_zero_ext", d, 32'h8000_14CF);
        wr(2'd0, 32'd0);
`else
        status_is("s2_zero_drop", 32'h0001_0000);
`endif

        // repeat suppression
        wr(2'd2, 32'h7);
        for (int i = 0; i < 5; i++) stb(13'h1A4D, 10);
        status_is("held_key", 32'h0000_0001);
        stb(13'h124D, 1);
        status_is("toggle_flip", 32'h0000_0002);
        wr(2'd0, 32'd0);
        repeat (130 * MS) @(negedge clk);
        stb(13'h124D, 1);
        status_is("after_window", 32'h0000_0002);

        // address filter
        wr(2'd3, 32'h105);
        stb(13'h1A4E, 1);
        status_is("filter_drop", 32'h0000_0002);
        stb(13'h1941, 1);
        status_is("filter_pass", 32'h0000_0003);
        rd(2'd3, d);
        chk("filter_reg", d, 32'h0000_0105);

        // fill, overflow, sticky clear
        wr(2'd3, 32'h0);
        for (int i = 0; i < 5; i++) stb(13'h1150 + 13'(i), 1);
        status_is("full", 32'h0002_0008);
        stb(13'h1155, 1);
        status_is("overflow", 32'h0006_0008);
        wr(2'd1, 32'h0004_0000);
        status_is("overflow_clear", 32'h0002_0008);

        // full FIFO: pop coincident with push
        @(negedge clk);
        frame_data = 13'h1156;
        frame_stb = 1'b1;
        @(negedge clk);
        frame_stb = 1'b0;
        csr_a = {SEL, 8'h00, 2'd0};
        csr_we = 1'b1;
        @(negedge clk);
        csr_we = 1'b0;
        csr_a = '0;
        repeat (MS) @(negedge clk);
        status_is("full_push_pop", 32'h0002_0008);
        chk("full_irq", {31'd0, irq}, 32'd1);

        // asynchronous reset mid-stream
        rd(2'd1, d);
        @(negedge clk);
        #2 rst_n = 1'b0;
        #1;
        chk("async_rst_do", csr_do, 32'd0);
        chk("async_rst_irq", {31'd0, irq}, 32'd0);
        repeat (2) @(negedge clk);
        rst_n = 1'b1;
        status_is("post_rst_status", 32'h0001_0000);
        rd(2'd2, d);
        chk("post_rst_ctrl", d, 32'd0);
        rd(2'd0, d);
        chk("post_rst_data", d, 32'd0);

        repeat (3) @(negedge clk);
        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end
endmodule
